// File: rtl/scan_code_event_decoder.sv
// Scan-code byte stream to key event decoder: E0/F0 prefix FSM with a prefix
// timeout, feeding a FIFO of {ext, brk, code} events with a sticky overflow flag.
module scan_code_event_decoder #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                        FCLK,
   input  logic                        RESET_N,
   input  logic [7:0]                  SCAN_IN,
   output logic                        EVT_VALID,
   input  logic                        EVT_READY,
   output logic [7:0]                  EVT_CODE,
   output logic                        EVT_BREAK,
   output logic                        EVT_EXT,
   output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
   output logic                        OVERFLOW
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

   state_t        state, state_next;
   logic [7:0]    scan_prev;
   logic          strobe;
   logic [TW-1:0] to_cnt;
   logic          timed_out;
   logic          push_evt;
   logic          ev_ext, ev_brk;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          full, pop, do_push;
   logic [9:0]    head;

   assign strobe    = (SCAN_IN != 8'h00) && (SCAN_IN != scan_prev);
   assign timed_out = (state != IDLE) && !strobe && (to_cnt == TO_LAST);

   always_ff @(posedge FCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         scan_prev <= 8'h00;
         to_cnt    <= '0;
      end else begin
         scan_prev <= SCAN_IN;
         if (state == IDLE || strobe)
            to_cnt <= '0;
         else if (to_cnt != TO_LAST)
            to_cnt <= to_cnt + TW'(1);
      end
   end

   always_ff @(posedge FCLK or negedge RESET_N) begin
      if (!RESET_N)
         state <= IDLE;
      else
         state <= state_next;
   end

   // A strobe always wins over a timeout landing on the same cycle.
   always_comb begin
      state_next = state;
      if (strobe) begin
         if (SCAN_IN == 8'hE0)
            state_next = GOT_E0;
         else if (SCAN_IN == 8'hF0) begin
            if (state == IDLE)
               state_next = GOT_F0;
            else if (state == GOT_E0)
               state_next = GOT_E0F0;
         end else
            state_next = IDLE;
      end else if (timed_out)
         state_next = IDLE;
   end

   always_comb begin
      push_evt = strobe && (SCAN_IN != 8'hE0) && (SCAN_IN != 8'hF0);
      ev_ext   = (state == GOT_E0) || (state == GOT_E0F0);
      ev_brk   = (state == GOT_F0) || (state == GOT_E0F0);
   end

   assign full    = (count == FULL_COUNT);
   assign pop     = (count != '0) && EVT_READY;
   assign do_push = push_evt && (!full || pop);

   always_ff @(posedge FCLK) begin
      if (do_push)
         mem[wptr] <= {ev_ext, ev_brk, SCAN_IN};
   end

   always_ff @(posedge FCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (do_push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         if (push_evt && full && !pop)
            OVERFLOW <= 1'b1;
      end
   end

   // Payload is forced to zero while empty so reset and idle outputs are clean.
   assign head       = mem[rptr];
   assign EVT_VALID  = (count != '0);
   assign FIFO_COUNT = count;
   assign EVT_CODE   = EVT_VALID ? head[7:0] : 8'h00;
   assign EVT_BREAK  = EVT_VALID & head[8];
   assign EVT_EXT    = EVT_VALID & head[9];

endmodule

// File: tb/tb_scan_code_event_decoder.sv
// Directed bench for scan_code_event_decoder: a per-cycle vector table plus
// hand-written timeout and reset sequences.
module tb_scan_code_event_decoder;

   localparam int DEPTH = 4;
   localparam int TO    = 16;

   logic       FCLK = 1'b0;
   logic       RESET_N;
   logic [7:0] SCAN_IN;
   logic       EVT_VALID;
   logic       EVT_READY;
   logic [7:0] EVT_CODE;
   logic       EVT_BREAK;
   logic       EVT_EXT;
   logic [2:0] FIFO_COUNT;
   logic       OVERFLOW;

   int vectors    = 0;
   int miscompares = 0;

   scan_code_event_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .FCLK       (FCLK),
      .RESET_N    (RESET_N),
      .SCAN_IN    (SCAN_IN),
      .EVT_VALID  (EVT_VALID),
      .EVT_READY  (EVT_READY),
      .EVT_CODE   (EVT_CODE),
      .EVT_BREAK  (EVT_BREAK),
      .EVT_EXT    (EVT_EXT),
      .FIFO_COUNT (FIFO_COUNT),
      .OVERFLOW   (OVERFLOW)
   );

   always #5 FCLK = ~FCLK;

   typedef struct {
      logic [7:0] scan;
      logic       rdy;
      logic       valid;
      logic [7:0] code;
      logic       brk;
      logic       ext;
      logic [2:0] count;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [7:0] s, input logic r, input logic v,
                               input logic [7:0] c, input logic b, input logic e,
                               input logic [2:0] n, input logic o);
      vec_t t;
      t.scan = s; t.rdy = r; t.valid = v; t.code = c;
      t.brk = b; t.ext = e; t.count = n; t.ovf = o;
      return t;
   endfunction

   task automatic step();
      @(posedge FCLK);
      #1;
   endtask

   // Payload fields are only compared when they are defined (head valid or in reset).
   task automatic check(input string name, input logic ev, input logic [7:0] ec,
                        input logic eb, input logic ee, input logic [2:0] en,
                        input logic eo, input bit payload);
      logic ok;
      ok = (EVT_VALID === ev) && (FIFO_COUNT === en) && (OVERFLOW === eo);
      if (payload)
         ok = ok && (EVT_CODE === ec) && (EVT_BREAK === eb) && (EVT_EXT === ee);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got valid=%b code=%h brk=%b ext=%b count=%0d ovf=%b, expected valid=%b code=%h brk=%b ext=%b count=%0d ovf=%b",
                  name, EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT, FIFO_COUNT, OVERFLOW,
                  ev, ec, eb, ee, en, eo);
      end
   endtask

   initial begin
      // single byte held with ready high
      vecs.push_back(mk(8'h1C,1, 1,8'h1C,0,0, 3'd1,0));
      vecs.push_back(mk(8'h1C,1, 0,8'h00,0,0, 3'd0,0));
      vecs.push_back(mk(8'h1C,1, 0,8'h00,0,0, 3'd0,0));
      vecs.push_back(mk(8'h1C,1, 0,8'h00,0,0, 3'd0,0));
      vecs.push_back(mk(8'h1C,1, 0,8'h00,0,0, 3'd0,0));
      vecs.push_back(mk(8'h00,1, 0,8'h00,0,0, 3'd0,0));
      // F0, 00, 1C
      vecs.push_back(mk(8'hF0,0, 0,8'h00,0,0, 3'd0,0));
      vecs.push_back(mk(8'h00,0, 0,8'h00,0,0, 3'd0,0));
      vecs.push_back(mk(8'h1C,0, 1,8'h1C,1,0, 3'd1,0));
      vecs.push_back(mk(8'h00,1, 0,8'h00,0,0, 3'd0,0));
      // E0, F0, 75
      vecs.push_back(mk(8'hE0,0, 0,8'h00,0,0, 3'd0,0));
      vecs.push_back(mk(8'hF0,0, 0,8'h00,0,0, 3'd0,0));
      vecs.push_back(mk(8'h75,0, 1,8'h75,1,1, 3'd1,0));
      vecs.push_back(mk(8'h00,1, 0,8'h00,0,0, 3'd0,0));
      // fill, overflow, drain
      vecs.push_back(mk(8'h15,0, 1,8'h15,0,0, 3'd1,0));
      vecs.push_back(mk(8'h1D,0, 1,8'h15,0,0, 3'd2,0));
      vecs.push_back(mk(8'h24,0, 1,8'h15,0,0, 3'd3,0));
      vecs.push_back(mk(8'h2D,0, 1,8'h15,0,0, 3'd4,0));
      vecs.push_back(mk(8'h2C,0, 1,8'h15,0,0, 3'd4,1));
      vecs.push_back(mk(8'h00,1, 1,8'h1D,0,0, 3'd3,1));
      vecs.push_back(mk(8'h00,1, 1,8'h24,0,0, 3'd2,1));
      vecs.push_back(mk(8'h00,1, 1,8'h2D,0,0, 3'd1,1));
      vecs.push_back(mk(8'h00,1, 0,8'h00,0,0, 3'd0,1));
      vecs.push_back(mk(8'h00,1, 0,8'h00,0,0, 3'd0,1));
      // push and pop together while full
      vecs.push_back(mk(8'h11,0, 1,8'h11,0,0, 3'd1,1));
      vecs.push_back(mk(8'h12,0, 1,8'h11,0,0, 3'd2,1));
      vecs.push_back(mk(8'h13,0, 1,8'h11,0,0, 3'd3,1));
      vecs.push_back(mk(8'h14,0, 1,8'h11,0,0, 3'd4,1));
      vecs.push_back(mk(8'h16,1, 1,8'h12,0,0, 3'd4,1));
      vecs.push_back(mk(8'h00,1, 1,8'h13,0,0, 3'd3,1));
      vecs.push_back(mk(8'h00,1, 1,8'h14,0,0, 3'd2,1));
      vecs.push_back(mk(8'h00,1, 1,8'h16,0,0, 3'd1,1));
      vecs.push_back(mk(8'h00,1, 0,8'h00,0,0, 3'd0,1));
      // E0 discards a pending F0
      vecs.push_back(mk(8'hF0,0, 0,8'h00,0,0, 3'd0,1));
      vecs.push_back(mk(8'hE0,0, 0,8'h00,0,0, 3'd0,1));
      vecs.push_back(mk(8'h1C,0, 1,8'h1C,0,1, 3'd1,1));
      vecs.push_back(mk(8'h00,1, 0,8'h00,0,0, 3'd0,1));
      // repeated F0 in GOT_E0F0 is ignored
      vecs.push_back(mk(8'hE0,0, 0,8'h00,0,0, 3'd0,1));
      vecs.push_back(mk(8'hF0,0, 0,8'h00,0,0, 3'd0,1));
      vecs.push_back(mk(8'h00,0, 0,8'h00,0,0, 3'd0,1));
      vecs.push_back(mk(8'hF0,0, 0,8'h00,0,0, 3'd0,1));
      vecs.push_back(mk(8'h5A,0, 1,8'h5A,1,1, 3'd1,1));
      vecs.push_back(mk(8'h00,1, 0,8'h00,0,0, 3'd0,1));

      RESET_N = 1'b0; SCAN_IN = 8'h00; EVT_READY = 1'b0;
      step(); step();
      check("reset", 0, 8'h00, 0, 0, 3'd0, 0, 1);
      RESET_N = 1'b1;

      foreach (vecs[i]) begin
         SCAN_IN = vecs[i].scan;
         EVT_READY = vecs[i].rdy;
         step();
         check($sformatf("vec%0d", i), vecs[i].valid, vecs[i].code, vecs[i].brk,
               vecs[i].ext, vecs[i].count, vecs[i].ovf, vecs[i].valid);
      end

      // E0 with TO-2 quiet cycles keeps the prefix
      EVT_READY = 1'b0;
      SCAN_IN = 8'hE0; step();
      SCAN_IN = 8'h00;
      for (int i = 0; i < TO - 2; i++) step();
      SCAN_IN = 8'h1C; step();
      check("to_short", 1, 8'h1C, 0, 1, 3'd1, 1, 1);
      SCAN_IN = 8'h00; EVT_READY = 1'b1; step();
      check("to_short_pop", 0, 8'h00, 0, 0, 3'd0, 1, 0);

      // E0 with TO quiet cycles times out silently
      EVT_READY = 1'b0;
      SCAN_IN = 8'hE0; step();
      SCAN_IN = 8'h00;
      for (int i = 0; i < TO; i++) step();
      check("to_no_event", 0, 8'h00, 0, 0, 3'd0, 1, 0);
      SCAN_IN = 8'h1C; step();
      check("to_expired", 1, 8'h1C, 0, 0, 3'd1, 1, 1);
      SCAN_IN = 8'h00; EVT_READY = 1'b1; step();
      EVT_READY = 1'b0;

      // reset mid-prefix with a stored event
      SCAN_IN = 8'h33; step();
      check("pre_reset_evt", 1, 8'h33, 0, 0, 3'd1, 1, 1);
      SCAN_IN = 8'hF0; step();
      SCAN_IN = 8'h00;
      RESET_N = 1'b0; #1;
      check("async_reset", 0, 8'h00, 0, 0, 3'd0, 0, 1);
      step(); step();
      check("held_reset", 0, 8'h00, 0, 0, 3'd0, 0, 1);
      RESET_N = 1'b1;
      SCAN_IN = 8'h1C; step();
      check("post_reset_evt", 1, 8'h1C, 0, 0, 3'd1, 0, 1);
      SCAN_IN = 8'h00; EVT_READY = 1'b1; step();
      EVT_READY = 1'b0;

      // byte already present at reset release strobes exactly once
      SCAN_IN = 8'h1C; RESET_N = 1'b0;
      step(); step();
      check("reset_with_byte", 0, 8'h00, 0, 0, 3'd0, 0, 1);
      RESET_N = 1'b1;
      step();
      check("release_strobe", 1, 8'h1C, 0, 0, 3'd1, 0, 1);
      for (int i = 0; i < 3; i++) step();
      check("release_single", 1, 8'h1C, 0, 0, 3'd1, 0, 1);
      EVT_READY = 1'b1; step();
      check("release_pop", 0, 8'h00, 0, 0, 3'd0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
